mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DATA_BITS, default 64, width of data path and register write-back value.
REQ-002 Ports, in order (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- exValid  in  1  MEM-stage instruction present this cycle.
- memRead  in  1  instruction is a load.
- regWrite  in  1  instruction writes rdAddr.
- loadType  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 7 reserved (treated as LD).
- addrLow  in  3  effective-address bits [2:0].
- aluResult  in  DATA_BITS  non-load write-back value.
- rdAddr  in  5  destination register.
- readDataMem  in  DATA_BITS  data-memory read word; valid the cycle after request.
- stall  in  1  hold both stages; upstream holds its inputs.
- flush  in  1  kill in-flight instruction.
- wbValid  out  1  write-back slot occupied this cycle.
- wbRegWrite  out  1  register-file write enable.
- wbRdAddr  out  5  register-file write address.
- wbData  out  DATA_BITS  register-file write data.
- misalignErr  out  1  one-cycle pulse coinciding with a misaligned load's wbValid.
- loadPending  out  1  stage 1 holds a valid load with regWrite=1 (interlock hint).

Function
REQ-003 Two registered stages: stage 1 (S1) tracks request; WB register drives all wb* outputs.
REQ-004 S1 captures {exValid, memRead, regWrite, loadType, addrLow, aluResult, rdAddr} on posedge when stall=0 and flush=0; S1 valid = exValid.
REQ-005 Latency: input at cycle N (stall=0) appears on wb* outputs in cycle N+2.
REQ-006 Capture register: first posedge after S1 loads a load, readDataMem is copied into holdData and flag captured=1; captured clears when S1 advances or is flushed.
REQ-007 Load source word = captured ? holdData : readDataMem.
REQ-008 Little-endian lane select: byte lane = addrLow; half lane = addrLow[2:1]; word lane = addrLow[2].
REQ-009 LB/LH/LW sign-extend the selected field to DATA_BITS; LBU/LHU/LWU zero-extend; LD passes all 64 bits.
REQ-010 Alignment: LH/LHU need addrLow[0]=0; LW/LWU need addrLow[1:0]=0; LD needs addrLow=0; LB/LBU always aligned.
REQ-011 Misaligned load: wbValid=1, wbRegWrite=0, misalignErr=1 for that one cycle; wbData don't-care.
REQ-012 Non-load: wbData = S1 aluResult; wbRegWrite = S1 regWrite.
REQ-013 On posedge with stall=0: WB register loads from S1 (wbValid = S1 valid, wbRegWrite = S1 valid & regWrite & aligned).
REQ-014 On posedge with stall=1 and flush=0: S1 and holdData hold; WB register takes a bubble (wbValid=0, wbRegWrite=0, misalignErr=0; wbData, wbRdAddr hold).
REQ-015 Flush has priority over stall: S1 valid cleared, incoming instruction discarded, captured cleared; WB register takes a bubble.
REQ-016 An instruction already in the WB register is not affected by flush.
REQ-017 loadPending = S1 valid & memRead & regWrite, combinational from S1 state.
REQ-018 Write to rdAddr 0 passes through unchanged; the register file discards it.

Reset
REQ-019 rst=1 asynchronously clears S1 valid, captured, holdData, wbValid, wbRegWrite, misalignErr, loadPending to 0, wbRdAddr to 0, wbData to 0.
REQ-020 Reset mid-operation discards all in-flight instructions; first capture occurs on the first posedge with rst=0.

Verification
REQ-021 LB, addrLow=3, readDataMem=0x0000_0000_8000_0000 -> cycle N+2: wbData=0xFFFF_FFFF_FFFF_FF80, wbRegWrite=1.
REQ-022 LWU, addrLow=4, readDataMem=0x8765_4321_0000_0000 -> wbData=0x0000_0000_8765_4321; same with LW -> 0xFFFF_FFFF_8765_4321.
REQ-023 LD, addrLow=2 -> wbValid=1, wbRegWrite=0, misalignErr=1 for exactly one cycle.
REQ-024 LH request, stall=1 for 3 cycles, readDataMem changes to garbage after cycle N+1 -> wbData from captured word; wbValid=0 during stall, one write-back after release.
REQ-025 stall=1 and flush=1 together with S1 holding a load -> no write-back, loadPending=0 next cycle.
REQ-026 rst asserted between posedges with S1 valid -> all outputs 0 immediately; no write-back after release.

Source files
------------

// File: rtl/mem_wb_if.sv
// MEM->WB bus: pipeline request, memory read data, stall/flush and write-back.
// slave = stage side, master = driver side (upstream, memory, register file).
interface mem_wb_if #(
    parameter int DATA_BITS = 64
);
    logic                 exValid;
    logic                 memRead;
    logic                 regWrite;
    logic [2:0]           loadType;
    logic [2:0]           addrLow;
    logic [DATA_BITS-1:0] aluResult;
    logic [4:0]           rdAddr;
    logic [DATA_BITS-1:0] readDataMem;
    logic                 stall;
    logic                 flush;
    logic                 wbValid;
    logic                 wbRegWrite;
    logic [4:0]           wbRdAddr;
    logic [DATA_BITS-1:0] wbData;
    logic                 misalignErr;
    logic                 loadPending;

    modport slave (
        input  exValid, memRead, regWrite, loadType, addrLow,
        input  aluResult, rdAddr, readDataMem, stall, flush,
        output wbValid, wbRegWrite, wbRdAddr, wbData,
        output misalignErr, loadPending
    );

    modport master (
        output exValid, memRead, regWrite, loadType, addrLow,
        output aluResult, rdAddr, readDataMem, stall, flush,
        input  wbValid, wbRegWrite, wbRdAddr, wbData,
        input  misalignErr, loadPending
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Two-register MEM/WB stage: S1 tracks the request, WB drives the register file.
// Ports: clk, rst (async, active-high), bus (mem_wb_if.slave).
module mem_wb_stage #(
    parameter int DATA_BITS = 64
) (
    input  logic      clk,
    input  logic      rst,
    mem_wb_if.slave   bus
);
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LBU = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LHU = 3'd3;
    localparam logic [2:0] LW  = 3'd4;
    localparam logic [2:0] LWU = 3'd5;

    logic                 s1_valid_q;
    logic                 s1_memRead_q;
    logic                 s1_regWrite_q;
    logic [2:0]           s1_loadType_q;
    logic [2:0]           s1_addrLow_q;
    logic [DATA_BITS-1:0] s1_alu_q;
    logic [4:0]           s1_rd_q;

    logic                 captured_q;
    logic [DATA_BITS-1:0] hold_q;

    logic                 wbValid_q;
    logic                 wbRegWrite_q;
    logic [4:0]           wbRdAddr_q;
    logic [DATA_BITS-1:0] wbData_q;
    logic                 misalign_q;

    logic [DATA_BITS-1:0] src_d;
    logic [7:0]           byte_d;
    logic [15:0]          half_d;
    logic [31:0]          word_d;
    logic [DATA_BITS-1:0] load_d;
    logic                 aligned_d;
    logic                 misaligned_d;
    logic                 advance_d;

    // Memory data is only valid one cycle; a stalled load keeps its copy.
    always_comb begin
        src_d     = captured_q ? hold_q : bus.readDataMem;
        byte_d    = 8'(src_d >> {s1_addrLow_q, 3'b000});
        half_d    = 16'(src_d >> {s1_addrLow_q[2:1], 4'b0000});
        word_d    = 32'(src_d >> {s1_addrLow_q[2], 5'b00000});
        load_d    = src_d;
        aligned_d = 1'b1;
        case (s1_loadType_q)
            LB:  load_d = {{(DATA_BITS-8){byte_d[7]}}, byte_d};
            LBU: load_d = {{(DATA_BITS-8){1'b0}}, byte_d};
            LH: begin
                load_d    = {{(DATA_BITS-16){half_d[15]}}, half_d};
                aligned_d = ~s1_addrLow_q[0];
            end
            LHU: begin
                load_d    = {{(DATA_BITS-16){1'b0}}, half_d};
                aligned_d = ~s1_addrLow_q[0];
            end
            LW: begin
                load_d    = {{(DATA_BITS-32){word_d[31]}}, word_d};
                aligned_d = (s1_addrLow_q[1:0] == 2'b00);
            end
            LWU: begin
                load_d    = {{(DATA_BITS-32){1'b0}}, word_d};
                aligned_d = (s1_addrLow_q[1:0] == 2'b00);
            end
            default: begin
                load_d    = src_d;
                aligned_d = (s1_addrLow_q == 3'd0);
            end
        endcase
        misaligned_d = s1_memRead_q & ~aligned_d;
        advance_d    = ~bus.stall & ~bus.flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_memRead_q  <= 1'b0;
            s1_regWrite_q <= 1'b0;
            s1_loadType_q <= 3'd0;
            s1_addrLow_q  <= 3'd0;
            s1_alu_q      <= '0;
            s1_rd_q       <= 5'd0;
        end else if (bus.flush) begin
            s1_valid_q    <= 1'b0;
        end else if (!bus.stall) begin
            s1_valid_q    <= bus.exValid;
            s1_memRead_q  <= bus.memRead;
            s1_regWrite_q <= bus.regWrite;
            s1_loadType_q <= bus.loadType;
            s1_addrLow_q  <= bus.addrLow;
            s1_alu_q      <= bus.aluResult;
            s1_rd_q       <= bus.rdAddr;
        end
    end

    // Capture only on the first stalled edge; later edges see stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured_q <= 1'b0;
            hold_q     <= '0;
        end else if (bus.flush || !bus.stall) begin
            captured_q <= 1'b0;
        end else if (s1_valid_q && s1_memRead_q && !captured_q) begin
            captured_q <= 1'b1;
            hold_q     <= bus.readDataMem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            misalign_q   <= 1'b0;
            wbRdAddr_q   <= 5'd0;
            wbData_q     <= '0;
        end else if (!advance_d) begin
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            wbValid_q    <= s1_valid_q;
            wbRegWrite_q <= s1_valid_q & s1_regWrite_q & ~misaligned_d;
            misalign_q   <= s1_valid_q & misaligned_d;
            wbRdAddr_q   <= s1_rd_q;
            wbData_q     <= s1_memRead_q ? load_d : s1_alu_q;
        end
    end

    assign bus.wbValid     = wbValid_q;
    assign bus.wbRegWrite  = wbRegWrite_q;
    assign bus.wbRdAddr    = wbRdAddr_q;
    assign bus.wbData      = wbData_q;
    assign bus.misalignErr = misalign_q;
    assign bus.loadPending = s1_valid_q & s1_memRead_q & s1_regWrite_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for loads/ALU results,
// plus stall-capture, flush and mid-cycle reset sequences.
module tb_mem_wb_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_wb_if #(.DATA_BITS(64)) bus ();

    mem_wb_stage #(.DATA_BITS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        rw;
        logic [2:0]  lt;
        logic [2:0]  al;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [4:0]  rda;
        logic [63:0] exp;
        logic        ew;
        logic        em;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.exValid     = 1'b0;
        bus.memRead     = 1'b0;
        bus.regWrite    = 1'b0;
        bus.loadType    = 3'd0;
        bus.addrLow     = 3'd0;
        bus.aluResult   = 64'd0;
        bus.rdAddr      = 5'd0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic drive(input logic mr, input logic rw, input logic [2:0] lt,
                         input logic [2:0] al, input logic [63:0] alu,
                         input logic [4:0] rda);
        bus.exValid   = 1'b1;
        bus.memRead   = mr;
        bus.regWrite  = rw;
        bus.loadType  = lt;
        bus.addrLow   = al;
        bus.aluResult = alu;
        bus.rdAddr    = rda;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        bus.readDataMem = 64'd0;

        v[0]  = '{1, 1, 3'd0, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 5'd1,
                  64'hFFFF_FFFF_FFFF_FF80, 1, 0};
        v[1]  = '{1, 1, 3'd5, 3'd4, 64'd0, 64'h8765_4321_0000_0000, 5'd2,
                  64'h0000_0000_8765_4321, 1, 0};
        v[2]  = '{1, 1, 3'd4, 3'd4, 64'd0, 64'h8765_4321_0000_0000, 5'd3,
                  64'hFFFF_FFFF_8765_4321, 1, 0};
        v[3]  = '{1, 1, 3'd6, 3'd2, 64'd0, 64'h1234, 5'd4, 64'd0, 0, 1};
        v[4]  = '{1, 1, 3'd1, 3'd7, 64'd0, 64'hAB00_0000_0000_0000, 5'd5,
                  64'h0000_0000_0000_00AB, 1, 0};
        v[5]  = '{1, 1, 3'd2, 3'd6, 64'd0, 64'h8001_0000_0000_0000, 5'd6,
                  64'hFFFF_FFFF_FFFF_8001, 1, 0};
        v[6]  = '{1, 1, 3'd3, 3'd2, 64'd0, 64'h0000_0000_F00D_0000, 5'd7,
                  64'h0000_0000_0000_F00D, 1, 0};
        v[7]  = '{1, 1, 3'd2, 3'd1, 64'd0, 64'h55, 5'd8, 64'd0, 0, 1};
        v[8]  = '{1, 1, 3'd4, 3'd2, 64'd0, 64'h66, 5'd9, 64'd0, 0, 1};
        v[9]  = '{1, 1, 3'd6, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd10,
                  64'h0123_4567_89AB_CDEF, 1, 0};
        v[10] = '{1, 1, 3'd7, 3'd0, 64'd0, 64'hFEDC_BA98_7654_3210, 5'd11,
                  64'hFEDC_BA98_7654_3210, 1, 0};
        v[11] = '{1, 1, 3'd0, 3'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF7F, 5'd12,
                  64'h0000_0000_0000_007F, 1, 0};
        v[12] = '{0, 1, 3'd6, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h9999, 5'd13,
                  64'hDEAD_BEEF_CAFE_F00D, 1, 0};
        v[13] = '{0, 0, 3'd0, 3'd0, 64'd5, 64'd0, 5'd14, 64'd5, 0, 0};
        v[14] = '{1, 0, 3'd4, 3'd0, 64'd0, 64'h0000_0000_8000_0001, 5'd15,
                  64'hFFFF_FFFF_8000_0001, 0, 0};
        v[15] = '{1, 1, 3'd3, 3'd0, 64'd0, 64'h1111_2222_3333_FFFF, 5'd0,
                  64'h0000_0000_0000_FFFF, 1, 0};

        // Reset state
        rst = 1'b1;
        #1;
        chk("rst_wbValid", 64'(bus.wbValid), 64'd0);
        chk("rst_wbRegWrite", 64'(bus.wbRegWrite), 64'd0);
        chk("rst_wbData", bus.wbData, 64'd0);
        chk("rst_wbRdAddr", 64'(bus.wbRdAddr), 64'd0);
        chk("rst_misalign", 64'(bus.misalignErr), 64'd0);
        chk("rst_loadPending", 64'(bus.loadPending), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: request at N, data at N+1, write-back at N+2
        for (int i = 0; i < 16; i++) begin
            drive(v[i].mr, v[i].rw, v[i].lt, v[i].al, v[i].alu, v[i].rda);
            @(negedge clk);
            idle();
            bus.readDataMem = v[i].rdata;
            chk($sformatf("v%0d_pending", i), 64'(bus.loadPending),
                64'(v[i].mr & v[i].rw));
            chk($sformatf("v%0d_early", i), 64'(bus.wbValid), 64'd0);
            @(negedge clk);
            bus.readDataMem = 64'hBAD0_BAD0_BAD0_BAD0;
            chk($sformatf("v%0d_valid", i), 64'(bus.wbValid), 64'd1);
            chk($sformatf("v%0d_we", i), 64'(bus.wbRegWrite), 64'(v[i].ew));
            chk($sformatf("v%0d_mis", i), 64'(bus.misalignErr), 64'(v[i].em));
            chk($sformatf("v%0d_rd", i), 64'(bus.wbRdAddr), 64'(v[i].rda));
            if (!v[i].em)
                chk($sformatf("v%0d_data", i), bus.wbData, v[i].exp);
        end
        @(negedge clk);
        chk("mis_pulse_end", 64'(bus.misalignErr), 64'd0);
        chk("tail_valid", 64'(bus.wbValid), 64'd0);

        // Stalled LH: data captured on first stalled edge, then garbage
        drive(1, 1, 3'd2, 3'd2, 64'd0, 5'd20);
        @(negedge clk);
        idle();
        bus.stall = 1'b1;
        bus.readDataMem = 64'h0000_0000_9ABC_0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.readDataMem = 64'hFFFF_0123_FFFF_FFFF;
            chk($sformatf("stall%0d_valid", c), 64'(bus.wbValid), 64'd0);
            chk($sformatf("stall%0d_pending", c), 64'(bus.loadPending), 64'd1);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        chk("stall_rel_valid", 64'(bus.wbValid), 64'd1);
        chk("stall_rel_we", 64'(bus.wbRegWrite), 64'd1);
        chk("stall_rel_data", bus.wbData, 64'hFFFF_FFFF_FFFF_9ABC);
        chk("stall_rel_rd", 64'(bus.wbRdAddr), 64'd20);
        @(negedge clk);
        chk("stall_once", 64'(bus.wbValid), 64'd0);

        // Stall+flush with load in S1: killed
        drive(1, 1, 3'd4, 3'd0, 64'd0, 5'd21);
        @(negedge clk);
        idle();
        bus.readDataMem = 64'h0000_0000_1234_5678;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        chk("sf_pending", 64'(bus.loadPending), 64'd0);
        chk("sf_valid0", 64'(bus.wbValid), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("sf_valid%0d", c + 1), 64'(bus.wbValid), 64'd0);
        end

        // Flush coincident with an incoming instruction discards it
        drive(0, 1, 3'd0, 3'd0, 64'h77, 5'd22);
        bus.flush = 1'b1;
        @(negedge clk);
        idle();
        chk("fl_in_pending", 64'(bus.loadPending), 64'd0);
        @(negedge clk);
        chk("fl_in_valid", 64'(bus.wbValid), 64'd0);

        // Reset between edges with WB and S1 both occupied
        drive(0, 1, 3'd0, 3'd0, 64'h4242, 5'd23);
        @(negedge clk);
        drive(1, 1, 3'd6, 3'd0, 64'd0, 5'd24);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(bus.wbValid), 64'd1);
        chk("pre_rst_pending", 64'(bus.loadPending), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.wbValid), 64'd0);
        chk("mid_rst_we", 64'(bus.wbRegWrite), 64'd0);
        chk("mid_rst_data", bus.wbData, 64'd0);
        chk("mid_rst_rd", 64'(bus.wbRdAddr), 64'd0);
        chk("mid_rst_pending", 64'(bus.loadPending), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid%0d", c), 64'(bus.wbValid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
